// File: rtl/matrix_pkg.sv
// Shared definitions for the HUB75 panel driver slice.
// Holds the default panel geometry, the row-scanner FSM state
// encoding and the packed {R,G,B} pixel type.
package matrix_pkg;

   localparam int unsigned COLS     = 32;
   localparam int unsigned COL_BITS = 5;
   localparam int unsigned ROW_BITS = 4;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_SET,
      SHIFT_CLK,
      BLANK,
      LATCH,
      UNLATCH,
      DISPLAY
   } state_t;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } pixel_t;

endpackage

// File: rtl/hub75_row_scanner.sv
// HUB75 row scanner for a 32x32, 1/16-scan panel.
// For each row pair, it fetches pixels from a registered frame buffer and
// shifts them into the panel. It then blanks, latches, selects the row and
// keeps it lit for DISP_STEPS steps. All activity advances only on `step`.
// Ports:
//   clk_fast, rst        - system clock, synchronous active-high reset
//   step                 - single-cycle advance pulse (prescaler output)
//   enable               - scanning runs while high
//   rd_row, rd_col       - frame buffer address (combinational from regs)
//   rd_data_top/bot      - {R,G,B} read data, valid 1 clk_fast after address
//   rgb_top, rgb_bot     - panel R1G1B1 / R2G2B2
//   sclk, lat, oe_n      - panel shift clock, latch, output enable (low)
//   row_addr             - panel A..D row select
//   frame_done           - one-cycle pulse after the last row pair is shown
module hub75_row_scanner #(
   parameter int unsigned COLS       = matrix_pkg::COLS,
   parameter int unsigned COL_BITS   = matrix_pkg::COL_BITS,
   parameter int unsigned ROW_BITS   = matrix_pkg::ROW_BITS,
   parameter int unsigned DISP_STEPS = 64
) (
   input  logic                clk_fast,
   input  logic                rst,
   input  logic                step,
   input  logic                enable,
   output logic [ROW_BITS-1:0] rd_row,
   output logic [COL_BITS-1:0] rd_col,
   input  logic [2:0]          rd_data_top,
   input  logic [2:0]          rd_data_bot,
   output logic [2:0]          rgb_top,
   output logic [2:0]          rgb_bot,
   output logic                sclk,
   output logic                lat,
   output logic                oe_n,
   output logic [ROW_BITS-1:0] row_addr,
   output logic                frame_done
);

   import matrix_pkg::state_t, matrix_pkg::pixel_t,
          matrix_pkg::IDLE, matrix_pkg::SHIFT_SET, matrix_pkg::SHIFT_CLK,
          matrix_pkg::BLANK, matrix_pkg::LATCH, matrix_pkg::UNLATCH,
          matrix_pkg::DISPLAY;

   localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(COLS - 1);
   localparam logic [15:0]         DISP_LAST = 16'(DISP_STEPS - 1);

   state_t              state, state_d;
   logic [COL_BITS-1:0] col, col_d;
   logic [ROW_BITS-1:0] shift_row, shift_row_d;
   logic [15:0]         disp_cnt, disp_cnt_d;
   pixel_t              top_q, top_d, bot_q, bot_d;
   logic                sclk_d, lat_d, oe_n_d, frame_done_d;
   logic [ROW_BITS-1:0] row_addr_d;

   assign rd_row  = shift_row;
   assign rd_col  = col;
   assign rgb_top = top_q;
   assign rgb_bot = bot_q;

   // State and output registers
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         state      <= IDLE;
         col        <= '0;
         shift_row  <= '0;
         disp_cnt   <= '0;
         top_q      <= '0;
         bot_q      <= '0;
         sclk       <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         row_addr   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         col        <= col_d;
         shift_row  <= shift_row_d;
         disp_cnt   <= disp_cnt_d;
         top_q      <= top_d;
         bot_q      <= bot_d;
         sclk       <= sclk_d;
         lat        <= lat_d;
         oe_n       <= oe_n_d;
         row_addr   <= row_addr_d;
         frame_done <= frame_done_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state;
      if (step) begin
         unique case (state)
            IDLE:      if (enable) state_d = SHIFT_SET;
            SHIFT_SET: state_d = SHIFT_CLK;
            SHIFT_CLK: state_d = (col == COL_LAST) ? BLANK : SHIFT_SET;
            BLANK:     state_d = LATCH;
            LATCH:     state_d = UNLATCH;
            UNLATCH:   state_d = DISPLAY;
            DISPLAY:   if (disp_cnt == DISP_LAST)
                          state_d = enable ? SHIFT_SET : IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   // Datapath and panel outputs; frame_done defaults low so it self-clears
   always_comb begin
      col_d        = col;
      shift_row_d  = shift_row;
      disp_cnt_d   = disp_cnt;
      top_d        = top_q;
      bot_d        = bot_q;
      sclk_d       = sclk;
      lat_d        = lat;
      oe_n_d       = oe_n;
      row_addr_d   = row_addr;
      frame_done_d = 1'b0;
      if (step) begin
         unique case (state)
            IDLE: begin
               oe_n_d = 1'b1;
               sclk_d = 1'b0;
               lat_d  = 1'b0;
               if (enable) col_d = '0;
            end
            SHIFT_SET: begin
               top_d  = pixel_t'(rd_data_top);
               bot_d  = pixel_t'(rd_data_bot);
               sclk_d = 1'b0;
            end
            SHIFT_CLK: begin
               sclk_d = 1'b1;
               if (col != COL_LAST) col_d = col + 1'b1;
            end
            BLANK: begin
               sclk_d = 1'b0;
               oe_n_d = 1'b1;
               col_d  = '0;
            end
            LATCH: begin
               lat_d      = 1'b1;
               row_addr_d = shift_row;
            end
            UNLATCH: begin
               lat_d      = 1'b0;
               oe_n_d     = 1'b0;
               disp_cnt_d = '0;
            end
            DISPLAY: begin
               disp_cnt_d = disp_cnt + 1'b1;
               if (disp_cnt == DISP_LAST) begin
                  oe_n_d       = 1'b1;
                  shift_row_d  = shift_row + 1'b1;
                  frame_done_d = &shift_row;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_row_scanner.sv
module tb_hub75_row_scanner;

   logic clk_fast = 1'b0;
   logic rst = 1'b0, step = 1'b0, enable = 1'b0;
   always #5 clk_fast = ~clk_fast;

   // DUT A: default timing; DUT B: DISP_STEPS = 1. Inputs are shared.
   logic [3:0] rd_row_a, row_addr_a, rd_row_b, row_addr_b;
   logic [4:0] rd_col_a, rd_col_b;
   logic [2:0] dtop_a, dbot_a, dtop_b, dbot_b;
   logic [2:0] rgb_top_a, rgb_bot_a, rgb_top_b, rgb_bot_b;
   logic sclk_a, lat_a, oe_n_a, fd_a, sclk_b, lat_b, oe_n_b, fd_b;

   hub75_row_scanner #(.COLS(32), .COL_BITS(5), .ROW_BITS(4), .DISP_STEPS(64)) dut_a (
      .clk_fast(clk_fast), .rst(rst), .step(step), .enable(enable),
      .rd_row(rd_row_a), .rd_col(rd_col_a),
      .rd_data_top(dtop_a), .rd_data_bot(dbot_a),
      .rgb_top(rgb_top_a), .rgb_bot(rgb_bot_a),
      .sclk(sclk_a), .lat(lat_a), .oe_n(oe_n_a),
      .row_addr(row_addr_a), .frame_done(fd_a));

   hub75_row_scanner #(.COLS(32), .COL_BITS(5), .ROW_BITS(4), .DISP_STEPS(1)) dut_b (
      .clk_fast(clk_fast), .rst(rst), .step(step), .enable(enable),
      .rd_row(rd_row_b), .rd_col(rd_col_b),
      .rd_data_top(dtop_b), .rd_data_bot(dbot_b),
      .rgb_top(rgb_top_b), .rgb_bot(rgb_bot_b),
      .sclk(sclk_b), .lat(lat_b), .oe_n(oe_n_b),
      .row_addr(row_addr_b), .frame_done(fd_b));

   // Registered frame buffer: top = column[2:0], bottom = its complement
   always_ff @(posedge clk_fast) begin
      dtop_a <= rd_col_a[2:0];
      dbot_a <= ~rd_col_a[2:0];
      dtop_b <= rd_col_b[2:0];
      dbot_b <= ~rd_col_b[2:0];
   end

   // Observed DUT selected by use_b
   logic use_b = 1'b0;
   logic [3:0] o_rd_row, o_row_addr;
   logic [4:0] o_rd_col;
   logic [2:0] o_top, o_bot;
   logic o_sclk, o_lat, o_oe_n, o_fd;
   always_comb begin
      o_rd_row   = use_b ? rd_row_b   : rd_row_a;
      o_rd_col   = use_b ? rd_col_b   : rd_col_a;
      o_row_addr = use_b ? row_addr_b : row_addr_a;
      o_top      = use_b ? rgb_top_b  : rgb_top_a;
      o_bot      = use_b ? rgb_bot_b  : rgb_bot_a;
      o_sclk     = use_b ? sclk_b     : sclk_a;
      o_lat      = use_b ? lat_b      : lat_a;
      o_oe_n     = use_b ? oe_n_b     : oe_n_a;
      o_fd       = use_b ? fd_b       : fd_a;
   end

   int n_total = 0, n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Snapshot taken on the negedge right after the step edge
   logic s_sclk, s_lat, s_oe_n, s_fd, s_fd_after;
   logic [2:0] s_top, s_bot;
   logic [3:0] s_row_addr, s_rd_row;
   logic [4:0] s_rd_col;

   // Entered and left on a negedge; one step pulse every `gap` cycles (gap >= 2)
   task automatic step_once(input int gap);
      step = 1'b1;
      @(negedge clk_fast);
      step = 1'b0;
      s_sclk = o_sclk; s_lat = o_lat; s_oe_n = o_oe_n; s_fd = o_fd;
      s_top = o_top; s_bot = o_bot; s_row_addr = o_row_addr;
      s_rd_row = o_rd_row; s_rd_col = o_rd_col;
      @(negedge clk_fast);
      s_fd_after = o_fd;
      repeat (gap - 2) @(negedge clk_fast);
   endtask

   // Steps one full row starting in SHIFT_SET, ending on the step that
   // raises oe_n after display. drop_rises >= 0 drops enable at that sclk rise.
   int r_steps, r_rises, r_bad, r_latched, r_lat, r_oe_low, r_ovl, r_fd, r_fdw;
   task automatic run_row(input int gap, input int drop_rises);
      logic prev_sclk;
      bit seen_low;
      r_steps = 0; r_rises = 0; r_bad = 0; r_latched = -1; r_lat = 0;
      r_oe_low = 0; r_ovl = 0; r_fd = 0; r_fdw = 0;
      seen_low = 0;
      prev_sclk = o_sclk;
      while (r_steps < 400) begin
         step_once(gap);
         r_steps++;
         if (s_sclk && !prev_sclk) begin
            if (s_top != 3'(r_rises % 8) || s_bot != ~3'(r_rises % 8)) r_bad++;
            r_rises++;
            if (r_rises == drop_rises) enable = 1'b0;
         end
         prev_sclk = s_sclk;
         if (s_lat) begin
            r_lat++;
            r_latched = int'(s_row_addr);
            if (!s_oe_n || s_sclk) r_ovl++;
         end
         if (s_fd) begin
            r_fd++;
            if (s_fd_after) r_fdw++;
         end
         if (!s_oe_n) begin
            r_oe_low++;
            seen_low = 1;
         end else if (seen_low) break;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_fast);
      rst = 1'b1;
      repeat (3) @(negedge clk_fast);
      rst = 1'b0;
      @(negedge clk_fast);
   endtask

   typedef struct {
      logic       en;
      logic       sclk, lat, oe_n;
      logic [2:0] top, bot;
      logic [4:0] col;
   } vec_t;
   vec_t vecs[7];

   int total_steps;
   int guard;

   initial begin
      // IDLE, SHIFT_SET(c0), SHIFT_CLK, SHIFT_SET(c1), SHIFT_CLK,
      // then enable drops mid-shift, which must not disturb the row
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 5'd0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 5'd0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 5'd1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 3'd6, 5'd1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd6, 5'd2};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 5'd2};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd5, 5'd3};

      // Reset with step pulsing: reset must win
      @(negedge clk_fast);
      rst = 1'b1; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step = (i != 1);
         @(negedge clk_fast);
      end
      step = 1'b0;
      chk("rst_oe_n", oe_n_a, 1);
      chk("rst_lat", lat_a, 0);
      chk("rst_sclk", sclk_a, 0);
      chk("rst_row_addr", row_addr_a, 0);
      chk("rst_rgb_top", rgb_top_a, 0);
      chk("rst_rgb_bot", rgb_bot_a, 0);
      chk("rst_frame_done", fd_a, 0);
      chk("rst_rd_col", rd_col_a, 0);
      chk("rst_rd_row", rd_row_a, 0);
      chk("rst_b_oe_n", oe_n_b, 1);
      rst = 1'b0;
      enable = 1'b0;
      @(negedge clk_fast);

      // Step in IDLE with enable low: nothing moves
      step_once(4);
      step_once(4);
      chk("idle_noen_sclk", s_sclk, 0);
      chk("idle_noen_oe_n", s_oe_n, 1);
      chk("idle_noen_rd_col", s_rd_col, 0);

      // Table-driven start of the first row
      for (int i = 0; i < 7; i++) begin
         enable = vecs[i].en;
         step_once(4);
         chk($sformatf("vec%0d_sclk", i), s_sclk, vecs[i].sclk);
         chk($sformatf("vec%0d_lat", i), s_lat, vecs[i].lat);
         chk($sformatf("vec%0d_oe_n", i), s_oe_n, vecs[i].oe_n);
         chk($sformatf("vec%0d_top", i), s_top, vecs[i].top);
         chk($sformatf("vec%0d_bot", i), s_bot, vecs[i].bot);
         chk($sformatf("vec%0d_rd_col", i), s_rd_col, vecs[i].col);
      end

      // Shift order and row 0 display, step every 4 cycles
      do_reset();
      enable = 1'b1;
      step_once(4);
      run_row(4, -1);
      chk("row0_rises", r_rises, 32);
      chk("row0_bad_data", r_bad, 0);
      chk("row0_lat_steps", r_lat, 1);
      chk("row0_latched", r_latched, 0);
      chk("row0_oe_low", r_oe_low, 64);
      chk("row0_steps", r_steps, 131);
      chk("row0_overlap", r_ovl, 0);
      total_steps = r_steps;

      // Rest of the frame
      for (int r = 1; r < 16; r++) begin
         run_row(2, -1);
         total_steps += r_steps;
         chk($sformatf("frame_row%0d_latched", r), r_latched, r);
         chk($sformatf("frame_row%0d_steps", r), r_steps, 131);
         chk($sformatf("frame_row%0d_fd", r), r_fd, (r == 15) ? 1 : 0);
      end
      chk("frame_total_steps", total_steps, 2096);
      chk("frame_done_width", r_fdw, 0);
      chk("frame_done_cleared", fd_a, 0);

      // Scanning restarts at row 0, then up to row 4
      for (int r = 0; r < 5; r++) begin
         run_row(2, -1);
         chk($sformatf("wrap_row%0d_latched", r), r_latched, r);
      end

      // Enable dropped at col 10 of row 5: row completes, then IDLE
      run_row(2, 11);
      chk("drop_latched", r_latched, 5);
      chk("drop_oe_low", r_oe_low, 64);
      chk("drop_rises", r_rises, 32);
      for (int i = 0; i < 3; i++) step_once(2);
      chk("drop_idle_oe_n", s_oe_n, 1);
      chk("drop_idle_sclk", s_sclk, 0);
      chk("drop_idle_lat", s_lat, 0);
      chk("drop_idle_rd_row", s_rd_row, 6);
      enable = 1'b1;
      step_once(2);
      run_row(2, -1);
      chk("resume_latched", r_latched, 6);

      // Reset during display of row 3
      do_reset();
      step_once(2);
      for (int r = 0; r < 3; r++) run_row(2, -1);
      guard = 0;
      do begin
         step_once(2);
         guard++;
      end while (s_oe_n && guard < 200);
      chk("mid_disp_reached", s_oe_n, 0);
      chk("mid_disp_row_addr", s_row_addr, 3);
      for (int i = 0; i < 5; i++) step_once(2);
      rst = 1'b1; step = 1'b1;
      @(negedge clk_fast);
      rst = 1'b0; step = 1'b0;
      chk("rst_disp_oe_n", oe_n_a, 1);
      chk("rst_disp_row_addr", row_addr_a, 0);
      chk("rst_disp_lat", lat_a, 0);
      chk("rst_disp_rgb_top", rgb_top_a, 0);
      @(negedge clk_fast);
      step_once(2);
      run_row(2, -1);
      chk("rst_disp_first_latch", r_latched, 0);

      // DISP_STEPS = 1 instance, step every 2 cycles
      use_b = 1'b1;
      do_reset();
      step_once(2);
      for (int r = 0; r < 2; r++) begin
         run_row(2, -1);
         chk($sformatf("short_row%0d_steps", r), r_steps, 68);
         chk($sformatf("short_row%0d_oe_low", r), r_oe_low, 1);
         chk($sformatf("short_row%0d_overlap", r), r_ovl, 0);
         chk($sformatf("short_row%0d_lat", r), r_lat, 1);
         chk($sformatf("short_row%0d_latched", r), r_latched, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hub75_row_scanner.md
Name: hub75_row_scanner

Overview:
- Downstream consumer of the prescaler tick. Drives a 32x32 HUB75 LED panel with 1/16 scan.
- For each row pair, it reads pixel bits from an external registered frame buffer and shifts 32 columns into the panel. It then blanks, latches, selects the row address and displays the row for a fixed number of ticks.
- All panel activity advances only on `step` pulses, so the prescaler output sets the panel clock rate.

Parameters:
- `COLS`, 32, columns per row; shift length.
- `COL_BITS`, 5, width of column index (log2 `COLS`).
- `ROW_BITS`, 4, width of row-pair address; 2**`ROW_BITS` row pairs.
- `DISP_STEPS`, 64, `step` pulses a row stays lit; range 1..2**16-1.

Ports:
- `clk_fast`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `step`  in  1  one-clk_fast-cycle enable pulse from prescaler `clk_slow`; never high on two consecutive cycles.
- `enable`  in  1  level; scanning runs while high.
- `rd_row`  out  `ROW_BITS`  frame buffer row-pair address.
- `rd_col`  out  `COL_BITS`  frame buffer column address.
- `rd_data_top`  in  3  {R,G,B} of upper-half pixel; valid 1 clk_fast after address.
- `rd_data_bot`  in  3  {R,G,B} of lower-half pixel; same timing.
- `rgb_top`  out  3  panel R1,G1,B1.
- `rgb_bot`  out  3  panel R2,G2,B2.
- `sclk`  out  1  panel shift clock.
- `lat`  out  1  panel latch.
- `oe_n`  out  1  panel output enable, active low.
- `row_addr`  out  `ROW_BITS`  panel A..D row select.
- `frame_done`  out  1  one-clk_fast pulse after the last row pair of a frame finishes display.

Behaviour:
- Reset values:
  - State IDLE; `col`=0; `shift_row`=0; `disp_cnt`=0.
  - `rgb_top`=`rgb_bot`=0; `sclk`=0; `lat`=0; `oe_n`=1; `row_addr`=0; `frame_done`=0.
- `rd_row`=`shift_row` and `rd_col`=`col`, both combinational from registers. Data is sampled only on `step`; because `step` pulses are at least 2 cycles apart, the address has been stable for ≥1 cycle when sampled.
- State and output registers change only on cycles with `step`=1, except `frame_done`, which clears to 0 the cycle after it pulses.
- FSM (each transition on a `step` cycle):
  - IDLE: `oe_n`=1, `sclk`=0, `lat`=0. If `enable`, go to SHIFT_SET with `col`=0.
  - SHIFT_SET: `rgb_top`<=`rd_data_top`, `rgb_bot`<=`rd_data_bot`, `sclk`<=0; go to SHIFT_CLK.
  - SHIFT_CLK: `sclk`<=1.
    - If `col`==`COLS`-1: go to BLANK.
    - Else: `col`<=`col`+1 and go to SHIFT_SET.
  - BLANK: `sclk`<=0, `oe_n`<=1, `col`<=0; go to LATCH.
  - LATCH: `lat`<=1, `row_addr`<=`shift_row`; go to UNLATCH.
  - UNLATCH: `lat`<=0, `oe_n`<=0, `disp_cnt`<=0; go to DISPLAY.
  - DISPLAY: `disp_cnt`<=`disp_cnt`+1 on each step. At `disp_cnt`==`DISP_STEPS`-1:
    - `oe_n`<=1 and `shift_row`<=`shift_row`+1 (modulo wrap).
    - If `shift_row` was all ones, pulse `frame_done` for 1 cycle.
    - Then go to SHIFT_SET if `enable`, else IDLE.
- Timing: a row takes 2·`COLS`+3+`DISP_STEPS` steps (131 at defaults). A frame is 16×131 = 2096 steps.
- `oe_n` is low only in DISPLAY.
- `lat` is high for exactly one step interval, always while `oe_n`=1 and `sclk`=0.
- Deasserting `enable` mid-row: the current row completes through DISPLAY, then the FSM enters IDLE. `shift_row` is retained, and the next enable resumes at that row.
- `rst` with `step` in the same cycle: reset wins.
- `rst` mid-shift or mid-display: all registers return to reset values on that edge, and the panel goes blank at once.
- `step` while `enable`=0 in IDLE: no change.
- Counter widths: `col` is `COL_BITS`; `disp_cnt` is 16 bits; `shift_row` is `ROW_BITS` with natural wrap.

Decomposition:
- Shared package `matrix_pkg`:
  - State enum (IDLE, SHIFT_SET, SHIFT_CLK, BLANK, LATCH, UNLATCH, DISPLAY).
  - Constants `COLS`, `COL_BITS`, `ROW_BITS` and panel pixel type {R,G,B}.
- No sub-module. The prescaler is instantiated alongside this block at the top level, with its `clk_slow` driving `step`.

Test Plan:
- Reset values: hold `rst`=1 for 3 cycles with `step` pulsing → `oe_n`=1, `lat`=0, `sclk`=0, `row_addr`=0, `rgb_*`=0, `frame_done`=0.
- Shift order: `enable`=1, `step` every 4 cycles, memory model returning `rd_data_top`=`rd_col`[2:0] → 32 `sclk` rising edges. On the k-th rise, `rgb_top`==k mod 8. Then one `lat` pulse with `row_addr`=0, then `oe_n` low for exactly 64 steps.
- Frame: run 2096 steps → `row_addr` sequence 0..15. `frame_done` pulses once, one cycle wide, at step 2096. Scanning restarts at row 0.
- Enable drop: drop `enable` during row 5 shift at `col`=10 → row 5 latches and displays 64 steps, then IDLE with `oe_n`=1. Re-enable → next latch has `row_addr`=6.
- Reset mid-display: assert `rst` with `step` during DISPLAY of row 3 → next edge `oe_n`=1, `row_addr`=0. After release, the first latch is row 0.
- Slow step, `DISP_STEPS`=1: `step` every 2 cycles → row period of 68 steps; `lat` never overlaps `oe_n`=0 or `sclk`=1.
